// File: rtl/apb_protocol_checker.sv
// Passive APB slave-side protocol checker: tracks IDLE/SETUP/ACCESS,
// flags violations (sticky, pulse, count) and counts completed transfers.
module apb_protocol_checker #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_WAIT   = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  apb_clk,
   input  logic                  apb_reset_n,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  chk_en,
   input  logic                  err_clr,
   output logic [4:0]            err_flags,
   output logic                  err_pulse,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [CNT_WIDTH-1:0]  xfer_count,
   output logic [DATA_WIDTH-1:0] rdata_cap,
   output logic                  rdata_valid
);

   localparam int WW = $clog2(MAX_WAIT + 2);
   localparam logic [WW-1:0] W_MAX = WW'(MAX_WAIT);
   localparam logic [WW-1:0] W_SAT = WW'(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_write;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [WW-1:0]         r_wait;
   logic [4:0]            r_flags;
   logic                  r_pulse;
   logic [CNT_WIDTH-1:0]  r_ecnt;
   logic [CNT_WIDTH-1:0]  r_xcnt;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_rvalid;

   state_t                w_next;
   logic                  w_latch;
   logic                  w_acc;
   logic                  w_done;
   logic                  w_ctrl_chg;
   logic [WW-1:0]         w_wcur;
   logic [4:0]            w_viol;
   logic [4:0]            w_err;
   logic                  w_any;

   assign w_ctrl_chg = (paddr != r_addr) || (pwrite != r_write) ||
                       (r_write && (pwdata != r_wdata));

   // SETUP with psel&penable is the first ACCESS sample of the transfer
   always_comb begin
      w_next  = r_state;
      w_latch = 1'b0;
      w_acc   = 1'b0;
      w_done  = 1'b0;
      w_viol  = '0;
      w_wcur  = r_wait;
      unique case (r_state)
         S_IDLE: begin
            if (penable) begin
               w_viol[0] = 1'b1;
            end else if (psel) begin
               w_next  = S_SETUP;
               w_latch = 1'b1;
            end
         end
         S_SETUP: begin
            if (psel && penable) begin
               w_acc  = 1'b1;
               w_wcur = '0;
            end else begin
               w_viol[1] = 1'b1;
               if (psel) begin
                  w_next  = S_SETUP;
                  w_latch = 1'b1;
               end else begin
                  w_next = S_IDLE;
               end
            end
         end
         S_ACCESS: begin
            if (!psel) begin
               w_viol[3] = 1'b1;
               w_next    = S_IDLE;
            end else if (!penable) begin
               w_viol[2] = 1'b1;
               w_next    = S_SETUP;
               w_latch   = 1'b1;
            end else begin
               w_acc = 1'b1;
            end
         end
         default: w_next = S_IDLE;
      endcase
      if (w_acc) begin
         w_viol[2] = w_ctrl_chg;
         if (pready) begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end else begin
            w_next    = S_ACCESS;
            w_viol[4] = (w_wcur == W_MAX);
         end
      end
   end

   assign w_err = chk_en ? w_viol : 5'b0;
   assign w_any = |w_err;

   always_ff @(posedge apb_clk or negedge apb_reset_n) begin
      if (!apb_reset_n) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_write  <= 1'b0;
         r_wdata  <= '0;
         r_wait   <= '0;
         r_flags  <= '0;
         r_pulse  <= 1'b0;
         r_ecnt   <= '0;
         r_xcnt   <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
         end
         // Counter parks one past MAX_WAIT so TIMEOUT fires once
         if (w_acc && !pready) begin
            r_wait <= (w_wcur == W_SAT) ? W_SAT : w_wcur + 1'b1;
         end else begin
            r_wait <= '0;
         end
         if (err_clr) begin
            r_flags <= w_err;
         end else begin
            r_flags <= r_flags | w_err;
         end
         r_pulse <= w_any;
         if (w_any && !(&r_ecnt)) begin
            r_ecnt <= r_ecnt + 1'b1;
         end
         if (w_done) begin
            r_xcnt <= r_xcnt + 1'b1;
         end
         if (w_done && !r_write) begin
            r_rdata <= prdata;
         end
         r_rvalid <= w_done && !r_write;
      end
   end

   assign err_flags   = r_flags;
   assign err_pulse   = r_pulse;
   assign err_count   = r_ecnt;
   assign xfer_count  = r_xcnt;
   assign rdata_cap   = r_rdata;
   assign rdata_valid = r_rvalid;

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Bench for apb_protocol_checker: three parameterisations on a shared bus,
// event outputs of the default instance scored against expectation queues.
module tb_apb_protocol_checker;

   logic       clk;
   logic       rst0, rst1, rst2;
   logic       psel, penable, pwrite, pready;
   logic [7:0] paddr, pwdata, prdata;
   logic       chk_en, err_clr;

   logic [4:0]  f0, f1, f2;
   logic        p0, p1, p2;
   logic [15:0] ec0, ec1, xc0, xc1;
   logic [3:0]  ec2, xc2;
   logic [7:0]  rd0, rd1, rd2;
   logic        rv0, rv1, rv2;

   int checks = 0;
   int failures = 0;

   logic [7:0] q_rd[$];
   logic [4:0] q_err[$];

   apb_protocol_checker u0 (
      .apb_clk(clk), .apb_reset_n(rst0),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .pready(pready), .chk_en(chk_en), .err_clr(err_clr),
      .err_flags(f0), .err_pulse(p0), .err_count(ec0),
      .xfer_count(xc0), .rdata_cap(rd0), .rdata_valid(rv0)
   );

   apb_protocol_checker #(.MAX_WAIT(0)) u1 (
      .apb_clk(clk), .apb_reset_n(rst1),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .pready(pready), .chk_en(chk_en), .err_clr(err_clr),
      .err_flags(f1), .err_pulse(p1), .err_count(ec1),
      .xfer_count(xc1), .rdata_cap(rd1), .rdata_valid(rv1)
   );

   apb_protocol_checker #(.CNT_WIDTH(4)) u2 (
      .apb_clk(clk), .apb_reset_n(rst2),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .pready(pready), .chk_en(chk_en), .err_clr(err_clr),
      .err_flags(f2), .err_pulse(p2), .err_count(ec2),
      .xfer_count(xc2), .rdata_cap(rd2), .rdata_valid(rv2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst0) begin
         if (rv0) begin
            if (q_rd.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rd_unexpected actual=%0h", rd0);
            end else begin
               chk("rdata_cap", 32'(rd0), 32'(q_rd.pop_front()));
            end
         end
         if (p0) begin
            if (q_err.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL pulse_unexpected flags=%0h", f0);
            end else begin
               chk("err_flags_at_pulse", 32'(f0), 32'(q_err.pop_front()));
            end
         end
      end
   end

   task automatic drive(input logic s, input logic e, input logic w,
                        input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] rd, input logic r);
      psel    = s;
      penable = e;
      pwrite  = w;
      paddr   = a;
      pwdata  = wd;
      prdata  = rd;
      pready  = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic xfer(input logic w, input logic [7:0] a,
                       input logic [7:0] wd, input logic [7:0] rd);
      drive(1'b1, 1'b0, w, a, wd, 8'h00, 1'b0);
      drive(1'b1, 1'b1, w, a, wd, rd, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst0 = 0; rst1 = 0; rst2 = 0;
      chk_en = 1; err_clr = 0;
      psel = 0; penable = 0; pwrite = 0; pready = 0;
      paddr = 0; pwdata = 0; prdata = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_flags", 32'(f0), 0);
      chk("rst_ecnt", 32'(ec0), 0);
      chk("rst_xcnt", 32'(xc0), 0);
      chk("rst_rdata", 32'(rd0), 0);
      chk("rst_pulse", 32'(p0), 0);
      chk("rst_rvalid", 32'(rv0), 0);
      rst0 = 1;
      idle();

      xfer(1'b1, 8'h10, 8'hA5, 8'h00);
      q_rd.push_back(8'h3C);
      xfer(1'b0, 8'h10, 8'h00, 8'h3C);
      chk("t1_xcnt", 32'(xc0), 2);
      chk("t1_rdata", 32'(rd0), 32'h3C);
      chk("t1_flags", 32'(f0), 0);
      idle();
      chk("t1_rvalid_one", 32'(rv0), 0);

      drive(1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 1'b0);
      q_err.push_back(5'b10000);
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 8'h77, 1'b0);
         if (i == 4) chk("t2_no_to_yet", 32'(f0), 0);
         if (i == 5) chk("t2_to_flag", 32'(f0), 32'b10000);
      end
      chk("t2_ecnt", 32'(ec0), 1);
      q_rd.push_back(8'h5A);
      drive(1'b1, 1'b1, 1'b0, 8'h20, 8'h00, 8'h5A, 1'b1);
      chk("t2_xcnt", 32'(xc0), 3);
      idle();

      err_clr = 1;
      idle();
      err_clr = 0;
      chk("t3_clr0", 32'(f0), 0);
      q_err.push_back(5'b00001);
      drive(1'b1, 1'b1, 1'b0, 8'h30, 8'h00, 8'h00, 1'b0);
      chk("t3_nosetup", 32'(f0), 32'b00001);
      err_clr = 1;
      idle();
      err_clr = 0;
      chk("t3_clr1", 32'(f0), 0);
      drive(1'b1, 1'b0, 1'b1, 8'h30, 8'h11, 8'h00, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 8'h30, 8'h11, 8'h00, 1'b0);
      q_err.push_back(5'b01000);
      err_clr = 1;
      idle();
      err_clr = 0;
      chk("t3_drop_wins", 32'(f0), 32'b01000);
      chk("t3_ecnt", 32'(ec0), 3);

      err_clr = 1;
      idle();
      err_clr = 0;
      chk_en = 0;
      drive(1'b1, 1'b0, 1'b0, 8'h40, 8'h00, 8'h00, 1'b0);
      idle();
      chk("t5_off_flags", 32'(f0), 0);
      chk("t5_off_ecnt", 32'(ec0), 3);
      chk_en = 1;
      xfer(1'b1, 8'h41, 8'h5C, 8'h00);
      chk("t5_on_flags", 32'(f0), 0);
      chk("t5_on_xcnt", 32'(xc0), 4);
      idle();

      rst0 = 0;
      rst1 = 1;
      idle();
      drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'h11, 8'h00, 8'h00, 1'b0);
      chk("t4_flags", 32'(f1), 32'b10100);
      chk("t4_ecnt", 32'(ec1), 1);
      chk("t4_pulse", 32'(p1), 1);
      drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 8'h66, 1'b1);
      chk("t4_ecnt_hold", 32'(ec1), 1);
      chk("t4_xcnt", 32'(xc1), 1);
      chk("t4_rdata", 32'(rd1), 32'h66);
      idle();

      rst1 = 0;
      rst2 = 1;
      idle();
      for (int i = 0; i < 15; i++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      end
      chk("t6_ecnt15", 32'(ec2), 15);
      drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      chk("t6_ecnt_sat", 32'(ec2), 15);
      chk("t6_flags", 32'(f2), 32'b00001);
      for (int i = 0; i < 15; i++) begin
         xfer(1'b1, 8'h50, 8'(i), 8'h00);
      end
      chk("t6_xcnt15", 32'(xc2), 15);
      xfer(1'b0, 8'h52, 8'h00, 8'h99);
      chk("t6_xcnt_wrap", 32'(xc2), 0);
      chk("t6_rdata", 32'(rd2), 32'h99);
      xfer(1'b1, 8'h53, 8'h01, 8'h00);
      drive(1'b1, 1'b0, 1'b1, 8'h50, 8'hAA, 8'h00, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 8'h51, 8'hAA, 8'h00, 1'b0);
      chk("t6_pre_pulse", 32'(p2), 1);
      chk("t6_pre_xcnt", 32'(xc2), 1);
      #2;
      rst2 = 0;
      #1;
      chk("t6_rst_flags", 32'(f2), 0);
      chk("t6_rst_ecnt", 32'(ec2), 0);
      chk("t6_rst_xcnt", 32'(xc2), 0);
      chk("t6_rst_rdata", 32'(rd2), 0);
      chk("t6_rst_pulse", 32'(p2), 0);
      chk("t6_rst_rvalid", 32'(rv2), 0);
      rst2 = 1;
      idle();
      xfer(1'b1, 8'h60, 8'h12, 8'h00);
      chk("t6_post_flags", 32'(f2), 0);
      chk("t6_post_xcnt", 32'(xc2), 1);
      chk("t6_post_ecnt", 32'(ec2), 0);
      idle();

      chk("q_rd_empty", 32'(q_rd.size()), 0);
      chk("q_err_empty", 32'(q_err.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
